// File: rtl/vga_mem_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_mem_port_arb                                             |
// | Description : Shares BRAM port A between the display line-buffer reader    |
// |               (fixed priority, deadline driven) and a frame writer. A      |
// |               starvation counter gives the writer one guaranteed slot      |
// |               after WR_MAX_WAIT consecutive stalled cycles.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i       pixel-domain clock                                           |
// |   rstn_i      synchronous reset, active low                                |
// |   rd_req_i    read request (held with rd_addr_i until granted)             |
// |   rd_addr_i   read address                                                 |
// |   rd_gnt_o    read accepted this cycle (combinational)                     |
// |   rd_data_o   read data, pass-through of mem_dout_i                        |
// |   rd_valid_o  rd_data_o valid, RD_LATENCY cycles after the read grant      |
// |   wr_req_i    write request (held with addr/data until granted)            |
// |   wr_addr_i   write address                                                |
// |   wr_data_i   write data                                                   |
// |   wr_gnt_o    write accepted this cycle (combinational)                    |
// |   wr_boost_o  high while the writer owns the priority slot                 |
// |   mem_en_o    BRAM port A enable                                           |
// |   mem_we_o    BRAM port A write enable                                     |
// |   mem_addr_o  BRAM port A address (0 when idle)                            |
// |   mem_din_o   BRAM port A write data (0 unless writing)                    |
// |   mem_dout_i  BRAM port A read data                                        |
// +----------------------------------------------------------------------------+
module vga_mem_port_arb #(
    parameter int MEM_WIDTH      = 8,
    parameter int MEM_DEPTH      = 38400,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH - 1),
    parameter int RD_LATENCY     = 1,
    parameter int WR_MAX_WAIT    = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      rd_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      rd_gnt_o,
    output logic [MEM_WIDTH-1:0]      rd_data_o,
    output logic                      rd_valid_o,
    input  logic                      wr_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [MEM_WIDTH-1:0]      wr_data_i,
    output logic                      wr_gnt_o,
    output logic                      wr_boost_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_WIDTH-1:0]      mem_din_o,
    input  logic [MEM_WIDTH-1:0]      mem_dout_i
);

    // A zero limit disables boosting; keep a 1-bit counter so widths stay legal.
    localparam int                 c_CTR_W      = (WR_MAX_WAIT > 0) ? $clog2(WR_MAX_WAIT + 1) : 1;
    localparam bit                 c_BOOST_EN   = (WR_MAX_WAIT > 0);
    localparam logic [c_CTR_W-1:0] c_WAIT_LIMIT = c_CTR_W'(WR_MAX_WAIT);

    localparam logic [0:0] c_ST_RD_PRI   = 1'b0;
    localparam logic [0:0] c_ST_WR_BOOST = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_CTR_W-1:0]    r_wait_ctr;
    logic [c_CTR_W-1:0]    w_wait_ctr_nxt;
    logic [c_CTR_W-1:0]    w_ctr_inc;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic                  w_wr_stall;
    logic                  w_boost_hit;
    logic [RD_LATENCY-1:0] r_vld_pipe;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= c_ST_RD_PRI;
            r_wait_ctr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_ctr <= w_wait_ctr_nxt;
        end
    end

    // ---------------------------------------------------------------- output logic
    // Grants are gated by rstn_i so the BRAM sees no access while reset is held.
    always_comb begin
        w_rd_gnt = 1'b0;
        w_wr_gnt = 1'b0;
        if (rstn_i) begin
            if (r_state == c_ST_WR_BOOST) begin
                w_wr_gnt = wr_req_i;
                w_rd_gnt = rd_req_i & ~wr_req_i;
            end else begin
                w_rd_gnt = rd_req_i;
                w_wr_gnt = wr_req_i & ~rd_req_i;
            end
        end
    end

    // ---------------------------------------------------------------- next-state logic
    assign w_wr_stall  = rstn_i & wr_req_i & ~w_wr_gnt;
    assign w_ctr_inc   = r_wait_ctr + c_CTR_W'(1);
    // The stall that would bring the counter to the limit triggers the boost instead.
    assign w_boost_hit = c_BOOST_EN && (r_state == c_ST_RD_PRI) && w_wr_stall
                         && (w_ctr_inc == c_WAIT_LIMIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_ctr_nxt = r_wait_ctr;
        case (r_state)
            c_ST_RD_PRI:   if (w_boost_hit) w_state_nxt = c_ST_WR_BOOST;
            c_ST_WR_BOOST: w_state_nxt = c_ST_RD_PRI;
            default:       w_state_nxt = c_ST_RD_PRI;
        endcase

        if (!c_BOOST_EN || w_wr_gnt || w_boost_hit) begin
            w_wait_ctr_nxt = '0;
        end else if (w_wr_stall) begin
            w_wait_ctr_nxt = w_ctr_inc;
        end
    end

    // ---------------------------------------------------------------- read-valid pipeline
    generate
        if (RD_LATENCY == 1) begin : g_vld_single
            always_ff @(posedge clk_i) begin
                if (!rstn_i) r_vld_pipe <= '0;
                else         r_vld_pipe <= w_rd_gnt;
            end
        end else begin : g_vld_multi
            always_ff @(posedge clk_i) begin
                if (!rstn_i) r_vld_pipe <= '0;
                else         r_vld_pipe <= {r_vld_pipe[RD_LATENCY-2:0], w_rd_gnt};
            end
        end
    endgenerate

    // ---------------------------------------------------------------- port outputs
    assign rd_gnt_o   = w_rd_gnt;
    assign wr_gnt_o   = w_wr_gnt;
    assign rd_data_o  = mem_dout_i;
    assign rd_valid_o = r_vld_pipe[RD_LATENCY-1];
    assign wr_boost_o = rstn_i & (r_state == c_ST_WR_BOOST);
    assign mem_en_o   = w_rd_gnt | w_wr_gnt;
    assign mem_we_o   = w_wr_gnt;
    assign mem_addr_o = w_wr_gnt ? wr_addr_i : (w_rd_gnt ? rd_addr_i : '0);
    assign mem_din_o  = w_wr_gnt ? wr_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_mem_port_arb                                          |
// | Description : Self-checking bench for vga_mem_port_arb. Three instances    |
// |               share one stimulus: A (lat 1, boost 16), B (lat 2, boost 16) |
// |               and C (lat 1, boost disabled).                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_mem_port_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rd_req, wr_req;
    logic [15:0] rd_addr, wr_addr;
    logic [7:0]  wr_data;

    logic        a_rd_gnt, a_rd_valid, a_wr_gnt, a_boost, a_en, a_we;
    logic [7:0]  a_rd_data, a_din, a_dout;
    logic [15:0] a_addr;
    logic        b_rd_gnt, b_rd_valid, b_wr_gnt, b_boost, b_en, b_we;
    logic [7:0]  b_rd_data, b_din, b_dout, b_d1;
    logic [15:0] b_addr;
    logic        c_rd_gnt, c_rd_valid, c_wr_gnt, c_boost, c_en, c_we;
    logic [7:0]  c_rd_data, c_din;
    logic [7:0]  c_dout = 8'h00;
    logic [15:0] c_addr;

    logic [7:0]  mem_a [0:63];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_mem_port_arb #(.RD_LATENCY(1), .WR_MAX_WAIT(16)) dut_a (
        .clk_i(clk), .rstn_i(rstn),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(a_rd_gnt),
        .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_gnt_o(a_wr_gnt), .wr_boost_o(a_boost),
        .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_addr),
        .mem_din_o(a_din), .mem_dout_i(a_dout));

    vga_mem_port_arb #(.RD_LATENCY(2), .WR_MAX_WAIT(16)) dut_b (
        .clk_i(clk), .rstn_i(rstn),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(b_rd_gnt),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_gnt_o(b_wr_gnt), .wr_boost_o(b_boost),
        .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_din_o(b_din), .mem_dout_i(b_dout));

    vga_mem_port_arb #(.RD_LATENCY(1), .WR_MAX_WAIT(0)) dut_c (
        .clk_i(clk), .rstn_i(rstn),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(c_rd_gnt),
        .rd_data_o(c_rd_data), .rd_valid_o(c_rd_valid),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_gnt_o(c_wr_gnt), .wr_boost_o(c_boost),
        .mem_en_o(c_en), .mem_we_o(c_we), .mem_addr_o(c_addr),
        .mem_din_o(c_din), .mem_dout_i(c_dout));

    // Initial BRAM contents: word i holds i*7+1 (mod 256).
    function automatic logic [7:0] pat(input logic [5:0] i);
        logic [7:0] t;
        t = {2'b00, i};
        return t * 8'd7 + 8'd1;
    endfunction

    // BRAM model for A: one-cycle registered read, writes update the array.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= pat(6'(i));
        end else if (a_en && a_we) begin
            mem_a[a_addr[5:0]] <= a_din;
        end else if (a_en) begin
            a_dout <= mem_a[a_addr[5:0]];
        end
    end

    // BRAM model for B: read-only pattern, two-cycle read latency.
    always @(posedge clk) begin
        if (b_en && !b_we) b_d1 <= pat(b_addr[5:0]);
        b_dout <= b_d1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rq, input logic [15:0] ra, input logic wq,
                         input logic [15:0] wa, input logic [7:0] wd);
        rd_req  = rq;
        rd_addr = ra;
        wr_req  = wq;
        wr_addr = wa;
        wr_data = wd;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rq;
        logic [15:0] ra;
        logic        wq;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic [29:0] exp;      // {rd_gnt, wr_gnt, en, we, addr, din, boost, rd_valid}
        logic [7:0]  exp_data; // checked only when rd_valid is expected
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic wb;
        logic e_vld;

        vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, {4'b0000, 16'h0000, 8'h00, 2'b00}, 8'h00};
        vecs[1] = '{1'b1, 16'h0005, 1'b0, 16'h0000, 8'h00, {4'b1010, 16'h0005, 8'h00, 2'b00}, 8'h00};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0009, 8'hA5, {4'b0111, 16'h0009, 8'hA5, 2'b01}, pat(6'd5)};
        vecs[3] = '{1'b1, 16'h0003, 1'b1, 16'h0009, 8'h3C, {4'b1010, 16'h0003, 8'h00, 2'b00}, 8'h00};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h0009, 8'h3C, {4'b0111, 16'h0009, 8'h3C, 2'b01}, pat(6'd3)};
        vecs[5] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 8'h00, {4'b1010, 16'hFFFF, 8'h00, 2'b00}, 8'h00};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, {4'b0000, 16'h0000, 8'h00, 2'b01}, pat(6'd63)};

        // Reset with both requests asserted: nothing may reach the BRAM.
        rstn = 1'b0;
        drive(1'b1, 16'h0004, 1'b1, 16'h0006, 8'hFF);
        @(negedge clk);
        chk("reset_a", 32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_addr, a_din, a_boost, a_rd_valid}), 32'h0);
        chk("reset_b", 32'({b_rd_gnt, b_wr_gnt, b_en, b_boost, b_rd_valid}), 32'h0);
        nxt();
        rstn = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
        nxt();

        // Single read: same-cycle grant, data one cycle later.
        drive(1'b1, 16'h0005, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("rd1_grant", 32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_addr}), 32'({4'b1010, 16'h0005}));
        nxt();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("rd1_data", 32'({a_rd_valid, a_rd_data}), 32'({1'b1, pat(6'd5)}));
        nxt();
        @(negedge clk);
        chk("rd1_vld_once", 32'(a_rd_valid), 32'h0);
        nxt();

        // Table-driven combinational vectors on A.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].rq, vecs[i].ra, vecs[i].wq, vecs[i].wa, vecs[i].wd);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_addr, a_din, a_boost, a_rd_valid}),
                32'(vecs[i].exp));
            if (vecs[i].exp[0]) chk($sformatf("vec%0d_data", i), 32'(a_rd_data), 32'(vecs[i].exp_data));
            nxt();
        end

        // Simultaneous requests: read first, write next cycle, no boost.
        drive(1'b1, 16'h000A, 1'b1, 16'h000C, 8'h5A);
        @(negedge clk);
        chk("coll_c0", 32'({a_rd_gnt, a_wr_gnt, a_boost}), 32'b100);
        nxt();
        drive(1'b0, 16'h0, 1'b1, 16'h000C, 8'h5A);
        @(negedge clk);
        chk("coll_c1", 32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_addr, a_din, a_boost}),
            32'({4'b0111, 16'h000C, 8'h5A, 1'b0}));
        chk("coll_c1_rd", 32'({a_rd_valid, a_rd_data}), 32'({1'b1, pat(6'd10)}));
        nxt();
        drive(1'b1, 16'h000C, 1'b0, 16'h0, 8'h00);
        nxt();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("wr_readback", 32'({a_rd_valid, a_rd_data}), 32'({1'b1, 8'h5A}));
        nxt();

        // Back-to-back burst of 8 reads on the two-cycle-latency instance.
        for (int k = 0; k < 3; k++) nxt();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(1'b1, 16'(k), 1'b0, 16'h0, 8'h00);
            else       drive(1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
            @(negedge clk);
            e_vld = (k >= 2) && (k <= 9);
            chk($sformatf("burst_b%0d", k),
                32'({b_rd_gnt, b_rd_valid, b_rd_valid ? b_rd_data : 8'h00}),
                32'({(k < 8), e_vld, e_vld ? pat(6'(k - 2)) : 8'h00}));
            nxt();
        end

        // Reset with reads in flight: the pending data is discarded.
        drive(1'b1, 16'h0001, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        chk("flush_rd0", 32'(b_rd_gnt), 32'h1);
        nxt();
        drive(1'b1, 16'h0002, 1'b0, 16'h0, 8'h00);
        nxt();
        rstn = 1'b0;
        drive(1'b1, 16'h0003, 1'b1, 16'h001E, 8'h11);
        @(negedge clk);
        chk("flush_rst_a", 32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_addr, a_din, a_boost}), 32'h0);
        chk("flush_pre_b", 32'({b_rd_valid, b_rd_data}), 32'({1'b1, pat(6'd1)}));
        nxt();
        rstn = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("flush_post%0d", k), 32'({a_rd_valid, b_rd_valid}), 32'h0);
            nxt();
        end

        // Starvation: build up stalls, reset, then expect boost every 17 cycles.
        drive(1'b1, 16'h0007, 1'b1, 16'h0014, 8'h77);
        for (int k = 0; k < 10; k++) nxt();
        rstn = 1'b0;
        @(negedge clk);
        chk("starve_rst_a", 32'({a_rd_gnt, a_wr_gnt, a_en, a_we, a_boost}), 32'h0);
        chk("starve_rst_c", 32'({c_rd_gnt, c_wr_gnt, c_en, c_boost}), 32'h0);
        nxt();
        rstn = 1'b1;
        for (int k = 0; k < 102; k++) begin
            @(negedge clk);
            wb = ((k % 17) == 16);
            chk($sformatf("starve_a%0d", k), 32'({a_rd_gnt, a_wr_gnt, a_we, a_boost}),
                32'({~wb, wb, wb, wb}));
            chk($sformatf("noboost_c%0d", k), 32'({c_rd_gnt, c_wr_gnt, c_boost}), 32'b100);
            if (k == 0) chk("starve_flush_b", 32'(b_rd_valid), 32'h0);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
